// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-window debounce,
// clean level plus one-cycle press/release pulses and a press-toggled enable.
module btn_debounce #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 5
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_IN,
   output logic BTN_LEVEL,
   output logic PRESS,
   output logic RELEASE,
   output logic TOGGLE
);

   localparam logic [1:0] IDLE_LO = 2'b00;
   localparam logic [1:0] WAIT_HI = 2'b01;
   localparam logic [1:0] IDLE_HI = 2'b10;
   localparam logic [1:0] WAIT_LO = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             sync0;
   logic             sync1;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             diff;
   logic             commit;

   // Encoding keeps the committed level in state[1].
   assign BTN_LEVEL = state[1];
   assign diff      = sync1 != state[1];
   assign commit    = diff && (cnt == CNT_MAX);

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE_LO: if (sync1)  state_nxt = WAIT_HI;
         WAIT_HI: begin
            if (!sync1)      state_nxt = IDLE_LO;
            else if (commit) state_nxt = IDLE_HI;
         end
         IDLE_HI: if (!sync1) state_nxt = WAIT_LO;
         WAIT_LO: begin
            if (sync1)       state_nxt = IDLE_HI;
            else if (commit) state_nxt = IDLE_LO;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync0   <= 1'b0;
         sync1   <= 1'b0;
         cnt     <= '0;
         state   <= IDLE_LO;
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         TOGGLE  <= 1'b0;
      end else begin
         sync0 <= BTN_IN;
         sync1 <= sync0;
         state <= state_nxt;
         if (!diff || commit)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         PRESS   <= commit && sync1;
         RELEASE <= commit && !sync1;
         if (commit && sync1)
            TOGGLE <= ~TOGGLE;
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: vector table, corner sequences
// and random stimulus against a sliding-window reference model.
module tb_btn_debounce;

   localparam int S = 16;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic BTN_IN = 1'b0;
   logic BTN_LEVEL, PRESS, RELEASE, TOGGLE;

   int n_chk = 0;
   int n_err = 0;

   btn_debounce #(.STABLE_CYCLES(S), .CNT_W(5)) dut (
      .CLK(CLK), .RST(RST), .BTN_IN(BTN_IN),
      .BTN_LEVEL(BTN_LEVEL), .PRESS(PRESS),
      .RELEASE(RELEASE), .TOGGLE(TOGGLE)
   );

   always #5 CLK = ~CLK;

   // Reference: raw samples reach the logic two edges late; a commit
   // happens when the last S seen samples all oppose the level.
   bit raw[$] = '{1'b0, 1'b0};
   bit hist[$];
   bit m_lvl = 0, m_p = 0, m_r = 0, m_t = 0;

   always @(posedge CLK) begin
      bit s;
      bit all_diff;
      if (RST) begin
         raw = '{1'b0, 1'b0};
         hist.delete();
         m_lvl = 0; m_p = 0; m_r = 0; m_t = 0;
      end else begin
         s = raw[0];
         void'(raw.pop_front());
         raw.push_back(BTN_IN);
         m_p = 0; m_r = 0;
         hist.push_back(s);
         if (hist.size() > S) void'(hist.pop_front());
         all_diff = (hist.size() == S);
         foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 0;
         if (all_diff) begin
            m_lvl = !m_lvl;
            hist.delete();
            if (m_lvl) begin m_p = 1; m_t = !m_t; end
            else m_r = 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({BTN_LEVEL, PRESS, RELEASE, TOGGLE});
   endfunction

   // Drive for one edge, then compare against the model away from the edge.
   task automatic step(input logic b, input logic r);
      BTN_IN = b;
      RST = r;
      @(negedge CLK);
      chk("model", outs(), int'({m_lvl, m_p, m_r, m_t}));
   endtask

   // Holds b until PRESS or RELEASE shows; n is the observation index.
   task automatic wait_pulse(input logic b, output int n);
      n = 0;
      for (int i = 1; i <= 60; i++) begin
         step(b, 1'b0);
         if (PRESS || RELEASE) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk("pulse_timeout", 0, 1);
   endtask

   typedef struct {
      logic rst;
      logic btn;
      int   cyc;
      int   e_press;
      int   e_rel;
      logic e_lvl;
      logic e_tog;
   } vec_t;

   vec_t vt[11];

   initial begin
      int n, pc, rc;
      logic tog0;

      vt[0]  = '{1, 0,  5, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 40, 1, 0, 1, 1};
      vt[2]  = '{0, 0, 40, 0, 1, 0, 1};
      vt[3]  = '{0, 1, 15, 0, 0, 0, 1};
      vt[4]  = '{0, 0, 40, 0, 0, 0, 1};
      vt[5]  = '{0, 1, 16, 0, 0, 0, 1};
      vt[6]  = '{0, 0, 40, 1, 1, 0, 0};
      vt[7]  = '{0, 1, 40, 1, 0, 1, 1};
      vt[8]  = '{0, 0, 15, 0, 0, 1, 1};
      vt[9]  = '{0, 1, 40, 0, 0, 1, 1};
      vt[10] = '{0, 0, 40, 0, 1, 0, 1};

      // Reset held with a busy input.
      for (int i = 0; i < 100; i++) begin
         step(logic'((i / 3) % 2), 1'b1);
         chk("rst_hold", outs(), 0);
      end
      step(1'b0, 1'b0);
      chk("rst_release", outs(), 0);

      foreach (vt[k]) begin
         pc = 0;
         rc = 0;
         for (int c = 0; c < vt[k].cyc; c++) begin
            step(vt[k].btn, vt[k].rst);
            pc += int'(PRESS);
            rc += int'(RELEASE);
         end
         chk($sformatf("v%0d_press", k), pc, vt[k].e_press);
         chk($sformatf("v%0d_rel", k), rc, vt[k].e_rel);
         chk($sformatf("v%0d_lvl", k), int'(BTN_LEVEL), int'(vt[k].e_lvl));
         chk($sformatf("v%0d_tog", k), int'(TOGGLE), int'(vt[k].e_tog));
      end

      // Clean press latency and pulse width.
      tog0 = TOGGLE;
      wait_pulse(1'b1, n);
      chk("press_lat", n, S + 2);
      chk("press_is_press", int'(PRESS), 1);
      chk("press_lvl", int'(BTN_LEVEL), 1);
      chk("press_tog", int'(TOGGLE), int'(!tog0));
      step(1'b1, 1'b0);
      chk("press_width", int'(PRESS), 0);
      repeat (20) step(1'b1, 1'b0);
      tog0 = TOGGLE;
      wait_pulse(1'b0, n);
      chk("rel_lat", n, S + 2);
      chk("rel_is_rel", int'(RELEASE), 1);
      chk("rel_tog_keep", int'(TOGGLE), int'(tog0));
      repeat (20) step(1'b0, 1'b0);

      // Bounce bursts collapse into one press.
      pc = 0;
      for (int b = 0; b < 5; b++) begin
         repeat (3) begin step(1'b1, 1'b0); pc += int'(PRESS); end
         repeat (3) begin step(1'b0, 1'b0); pc += int'(PRESS); end
      end
      chk("bounce_early", pc, 0);
      wait_pulse(1'b1, n);
      chk("bounce_lat", n, S + 2);
      pc = 0;
      repeat (30) begin step(1'b1, 1'b0); pc += int'(PRESS); end
      chk("bounce_single", pc, 0);
      repeat (40) step(1'b0, 1'b0);

      // Reset in the middle of a count.
      repeat (12) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("midrst_outs", outs(), 0);
      wait_pulse(1'b1, n);
      chk("midrst_lat", n, S + 2);
      chk("midrst_tog", int'(TOGGLE), 1);

      // Random runs with occasional resets.
      for (int r = 0; r < 150; r++) begin
         logic b;
         int len;
         b = logic'($urandom_range(0, 1));
         len = $urandom_range(1, 2 * S);
         if ($urandom_range(0, 19) == 0)
            repeat ($urandom_range(1, 3)) step(b, 1'b1);
         repeat (len) begin
            step(b, 1'b0);
            chk("excl", int'(PRESS && RELEASE), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
